pipe_stall_ctrl: RTL

//  Parametrised stall/flush controller for an N-stage in-order pipeline (default 5: IF ID EX MA WB).

---
 rtl/pipe_stall_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// Hazard unit: arbitrates I-miss, D-miss, load-use and redirect into
// per-register stall/flush controls plus a PC hold. Also provides a miss
// watchdog and a saturating stall-cycle counter.
module pipe_stall_ctrl #(
  parameter int NUM_STAGES     = 5,
  parameter int REDIRECT_DEPTH = 2,
  parameter int MISS_TIMEOUT   = 64,
  parameter int CNT_W          = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  i_ICache_Miss,
  input  logic                  i_DCache_Miss,
  input  logic                  i_LoadUse,
  input  logic                  i_Redirect,
  output logic                  o_PC_Stall,
  output logic [NUM_STAGES-2:0] o_Stall,
  output logic [NUM_STAGES-2:0] o_Flush,
  output logic [1:0]            o_State,
  output logic                  o_Timeout,
  output logic [CNT_W-1:0]      o_StallCycles
);

  localparam int NREG = NUM_STAGES - 1;
  localparam int WW   = (MISS_TIMEOUT > 2) ? $clog2(MISS_TIMEOUT) : 1;

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DMISS  = 2'd1;
  localparam logic [1:0] S_IMISS  = 2'd2;
  localparam logic [1:0] S_LU_BUB = 2'd3;

  // Register masks: register k sits between stage k and k+1.
  localparam logic [NREG-1:0] ONE      = NREG'(1);
  localparam logic [NREG-1:0] DM_STALL = ~(ONE << (NREG - 1));   // freeze everything up to EX/MA
  localparam logic [NREG-1:0] DM_FLUSH = ONE << (NREG - 1);      // bubble into MA/WB
  localparam logic [NREG-1:0] ID_STALL = ONE;                    // hold IF/ID
  localparam logic [NREG-1:0] ID_FLUSH = ONE << 1;               // bubble into ID/EX
  localparam logic [NREG-1:0] RD_FLUSH = (ONE << REDIRECT_DEPTH) - ONE;

  localparam logic [WW-1:0] WAIT_MAX = WW'(MISS_TIMEOUT - 1);
  localparam logic [WW-1:0] WAIT_TRG = WW'(MISS_TIMEOUT - 2);

  logic [1:0]    state, nxt;
  logic [WW-1:0] wait_cnt;
  logic          lu_ok, same_miss;

  // A load already bubbled once; its re-asserted hazard is masked for one cycle.
  assign lu_ok   = i_LoadUse && (state != S_LU_BUB);
  assign o_State = state;

  // Priority arbitration; outputs are Mealy on registered state and live events.
  always_comb begin
    o_PC_Stall = 1'b0;
    o_Stall    = '0;
    o_Flush    = '0;
    nxt        = S_RUN;
    if (!Rst) begin
      o_Flush = '1;
    end else if (i_DCache_Miss) begin
      o_PC_Stall = 1'b1;
      o_Stall    = DM_STALL;
      o_Flush    = DM_FLUSH;
      nxt        = S_DMISS;
    end else if (lu_ok) begin
      o_PC_Stall = 1'b1;
      o_Stall    = ID_STALL;
      o_Flush    = ID_FLUSH;
      nxt        = S_LU_BUB;
    end else if (i_Redirect) begin
      // PC must load the redirect target, so an outstanding I-miss is dropped.
      o_Flush = RD_FLUSH;
    end else if (i_ICache_Miss) begin
      o_PC_Stall = 1'b1;
      o_Stall    = ID_STALL;
      o_Flush    = ID_FLUSH;
      nxt        = S_IMISS;
    end
  end

  // The same miss continues only when we stay in the same miss state.
  assign same_miss = ((state == S_DMISS) && (nxt == S_DMISS)) ||
                     ((state == S_IMISS) && (nxt == S_IMISS));

  // Controller state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= S_RUN;
    else      state <= nxt;
  end

  // Miss watchdog: consecutive-wait counter with a sticky timeout flag.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wait_cnt  <= '0;
      o_Timeout <= 1'b0;
    end else if (same_miss) begin
      if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt >= WAIT_TRG) o_Timeout <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Saturating count of PC-stall cycles.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                                   o_StallCycles <= '0;
    else if (o_PC_Stall && (o_StallCycles != '1)) o_StallCycles <= o_StallCycles + 1'b1;
  end

endmodule
